// File: rtl/dds_sweep_ctrl_if.sv
// Configuration bus for dds_sweep_ctrl: valid/ready handshake carrying the
// sweep start/stop words, step, phase word and per-step dwell length.
interface dds_sweep_ctrl_if #(
  parameter int unsigned DWELL_W = 24
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [31:0]        cfg_start_word;
  logic [31:0]        cfg_stop_word;
  logic [31:0]        cfg_step;
  logic [11:0]        cfg_phase;
  logic [DWELL_W-1:0] cfg_dwell;

  modport master (
    output cfg_valid, cfg_start_word, cfg_stop_word, cfg_step, cfg_phase, cfg_dwell,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_start_word, cfg_stop_word, cfg_step, cfg_phase, cfg_dwell,
    output cfg_ready
  );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency-sweep controller: steps f_word from start to stop word with a
// programmable dwell, rotates the waveform selector. Define DDS_SWEEP_BIDIR_EN
// for an up-then-down sweep.
module dds_sweep_ctrl #(
  parameter logic [31:0] F_DEFAULT = 32'd42949,
  parameter logic [11:0] P_DEFAULT = 12'd1024,
  parameter int unsigned DWELL_W   = 24
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            key_wave,
  input  logic            start,
  input  logic            stop,
  dds_sweep_ctrl_if.slave cfg,
  output logic [3:0]      wave_sel,
  output logic [31:0]     f_word,
  output logic [11:0]     p_word,
  output logic            busy,
  output logic            sweep_done
);

  typedef enum logic [1:0] {IDLE, DWELL, STEP, DONE} state_t;

  state_t             state, state_nxt;
  logic [31:0]        f_nxt;
  logic [31:0]        start_q, stop_q, step_q;
  logic [11:0]        p_nxt;
  logic [DWELL_W-1:0] dwell_q, cnt, cnt_nxt, dwell_load;
  logic               busy_nxt, done_nxt;
  logic               ready_q, ready_nxt;
  logic               cfg_take;
  logic [3:0]         wave_nxt;
  logic [32:0]        sum_up;
`ifdef DDS_SWEEP_BIDIR_EN
  logic               dir, dir_nxt;
  logic [32:0]        sum_dn;
`endif

  assign cfg.cfg_ready = ready_q;
  assign cfg_take      = cfg.cfg_valid && ready_q;
  assign dwell_load    = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
  assign sum_up        = {1'b0, f_word} + {1'b0, step_q};
`ifdef DDS_SWEEP_BIDIR_EN
  assign sum_dn        = {1'b0, f_word} - {1'b0, step_q};
`endif

  always_comb begin
    state_nxt = state;
    f_nxt     = f_word;
    cnt_nxt   = cnt;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
`ifdef DDS_SWEEP_BIDIR_EN
    dir_nxt   = dir;
`endif
    unique case (state)
      IDLE: begin
        if (start && (step_q != '0) && (start_q <= stop_q)) begin
          state_nxt = DWELL;
          f_nxt     = start_q;
          cnt_nxt   = dwell_load;
          busy_nxt  = 1'b1;
`ifdef DDS_SWEEP_BIDIR_EN
          dir_nxt   = 1'b0;
`endif
        end
      end
      DWELL: begin
        if (cnt <= DWELL_W'(1)) state_nxt = STEP;
        else                    cnt_nxt   = cnt - DWELL_W'(1);
      end
      STEP: begin
`ifdef DDS_SWEEP_BIDIR_EN
        // Up leg clamps at stop_q and turns around; down leg clamps at
        // start_q, and only a dwelled start_q ends the sweep.
        if ((!dir && (f_word == stop_q)) || (dir && (f_word == start_q))) begin
          state_nxt = DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else if (!dir) begin
          cnt_nxt   = dwell_load;
          state_nxt = DWELL;
          if (sum_up[32] || (sum_up[31:0] >= stop_q)) begin
            f_nxt   = stop_q;
            dir_nxt = 1'b1;
          end else begin
            f_nxt   = sum_up[31:0];
          end
        end else begin
          cnt_nxt   = dwell_load;
          state_nxt = DWELL;
          if (sum_dn[32] || (sum_dn[31:0] <= start_q)) f_nxt = start_q;
          else                                         f_nxt = sum_dn[31:0];
        end
`else
        if (sum_up[32] || (sum_up[31:0] >= stop_q)) begin
          f_nxt     = stop_q;
          state_nxt = DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          f_nxt     = sum_up[31:0];
          cnt_nxt   = dwell_load;
          state_nxt = DWELL;
        end
`endif
      end
      DONE: begin
        state_nxt = IDLE;
      end
    endcase

    if (stop) begin
      state_nxt = IDLE;
      f_nxt     = f_word;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
    end
  end

  always_comb begin
    ready_nxt = (state_nxt == IDLE);
    p_nxt     = cfg_take ? cfg.cfg_phase : p_word;
    wave_nxt  = wave_sel;
    if (!$onehot(wave_sel)) wave_nxt = 4'b0001;
    else if (key_wave)      wave_nxt = {wave_sel[2:0], wave_sel[3]};
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      f_word     <= F_DEFAULT;
      p_word     <= P_DEFAULT;
      wave_sel   <= 4'b0001;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
      ready_q    <= 1'b1;
      cnt        <= '0;
      start_q    <= F_DEFAULT;
      stop_q     <= F_DEFAULT;
      step_q     <= '0;
      dwell_q    <= DWELL_W'(1);
`ifdef DDS_SWEEP_BIDIR_EN
      dir        <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      f_word     <= f_nxt;
      p_word     <= p_nxt;
      wave_sel   <= wave_nxt;
      busy       <= busy_nxt;
      sweep_done <= done_nxt;
      ready_q    <= ready_nxt;
      cnt        <= cnt_nxt;
`ifdef DDS_SWEEP_BIDIR_EN
      dir        <= dir_nxt;
`endif
      if (cfg_take) begin
        start_q <= cfg.cfg_start_word;
        stop_q  <= cfg.cfg_stop_word;
        step_q  <= cfg.cfg_step;
        dwell_q <= cfg.cfg_dwell;
      end
    end
  end

endmodule
